// File: rtl/rvm_shift_dispatch_pkg.sv
// Shared encodings and payload types for the shift issue stage.
package rvm_shift_dispatch_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned CNT_W   = 8;

    // Shifter op encodings, shared with the rvm_shift datapath.
    typedef enum logic [OP_W-1:0] {
        RVM_SHIFT_NOP = 2'b00,
        RVM_SHIFT_SLL = 2'b01,
        RVM_SHIFT_SRL = 2'b10,
        RVM_SHIFT_SRA = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        RVM_SDISP_IDLE = 2'b00,
        RVM_SDISP_EXEC = 2'b01,
        RVM_SDISP_RESP = 2'b10
    } sdisp_state_e;

    typedef struct packed {
        shift_op_e            op;
        logic [DATA_W-1:0]    lhs;
        logic [SHAMT_W-1:0]   rhs;
    } shift_req_t;

endpackage

// File: rtl/rvm_shift_dispatch.sv
// Issue stage in front of the combinational shifter: registers one request,
// drives the shifter only while executing, and holds the result for writeback.
module rvm_shift_dispatch
    import rvm_shift_dispatch_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [OP_W-1:0]     req_op,
    input  logic [DATA_W-1:0]   req_lhs,
    input  logic [SHAMT_W-1:0]  req_rhs,
    output logic [DATA_W-1:0]   shf_lhs,
    output logic [SHAMT_W-1:0]  shf_rhs,
    output logic [OP_W-1:0]     shf_op,
    input  logic                shf_valid,
    input  logic [DATA_W-1:0]   shf_result,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_result,
    output logic                rsp_error
);

    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT);

    sdisp_state_e     state;
    shift_req_t       shf_q;
    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] tmo_inc;

    assign tmo_inc = tmo_cnt + CNT_W'(1);

    // Operand register doubles as the shifter drive; it is zero outside EXEC.
    assign shf_op  = shf_q.op;
    assign shf_lhs = shf_q.lhs;
    assign shf_rhs = shf_q.rhs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RVM_SDISP_IDLE;
            shf_q      <= '0;
            tmo_cnt    <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_error  <= 1'b0;
        end else if (flush) begin
            state     <= RVM_SDISP_IDLE;
            shf_q     <= '0;
            tmo_cnt   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                RVM_SDISP_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (shift_op_e'(req_op) == RVM_SHIFT_NOP) begin
                            state      <= RVM_SDISP_RESP;
                            rsp_valid  <= 1'b1;
                            rsp_result <= '0;
                            rsp_error  <= 1'b0;
                        end else begin
                            state     <= RVM_SDISP_EXEC;
                            tmo_cnt   <= '0;
                            shf_q.op  <= shift_op_e'(req_op);
                            shf_q.lhs <= req_lhs;
                            shf_q.rhs <= req_rhs;
                        end
                    end
                end
                RVM_SDISP_EXEC: begin
                    if (shf_valid) begin
                        state      <= RVM_SDISP_RESP;
                        shf_q      <= '0;
                        rsp_valid  <= 1'b1;
                        rsp_result <= shf_result;
                        rsp_error  <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_inc;
                        // Give up once this cycle brings the wait to the limit.
                        if (tmo_inc == TMO_LIM) begin
                            state      <= RVM_SDISP_RESP;
                            shf_q      <= '0;
                            rsp_valid  <= 1'b1;
                            rsp_result <= '0;
                            rsp_error  <= 1'b1;
                        end
                    end
                end
                RVM_SDISP_RESP: begin
                    if (rsp_ready) begin
                        state     <= RVM_SDISP_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= RVM_SDISP_IDLE;
                    shf_q     <= '0;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
